// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared widths and constants for the write-back register file
package wb_regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 1 << ADDR_W;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam word_t ZERO_WORD = '0;
  localparam addr_t REG_ZERO = '0;
endpackage

// File: rtl/wb_llbit_reg.sv
// wb_llbit_reg: LL/SC link flag with flush priority and same-cycle bypass
module wb_llbit_reg (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic we_i,
  input  logic value_i,
  output logic llbit_o
);
  logic llbit_q, llbit_d;
  always_comb llbit_d = (rst || flush_i) ? 1'b0 : we_i ? value_i : llbit_q;
  always_ff @(posedge clk) llbit_q <= llbit_d;
  // next state doubles as the bypassed output
  assign llbit_o = llbit_d;
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: GPRs, HI/LO and LLbit updated from the MEM/WB commit bundle
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              wb_LLbit_we,
  input  logic              wb_LLbit_value,
  input  logic              flush,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              LLbit_o
);
  word_t regs_q [NUM_REGS];
  word_t hi_q, lo_q;
  logic  re [2];
  addr_t raddr [2];
  word_t rdata [2];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= ZERO_WORD;
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else begin
      if (wb_we && wb_waddr != REG_ZERO) regs_q[wb_waddr] <= wb_wdata;
      if (wb_whilo) begin
        hi_q <= wb_hi;
        lo_q <= wb_lo;
      end
    end
  assign re[0] = re1;
  assign re[1] = re2;
  assign raddr[0] = raddr1;
  assign raddr[1] = raddr2;
  // read ports bypass the in-flight write so ID never sees stale data
  for (genvar k = 0; k < 2; k++) begin : g_rd
    assign rdata[k] = (rst || !re[k] || raddr[k] == REG_ZERO) ? ZERO_WORD :
                      (wb_we && raddr[k] == wb_waddr) ? wb_wdata : regs_q[raddr[k]];
  end
  assign rdata1 = rdata[0];
  assign rdata2 = rdata[1];
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  wb_llbit_reg u_llbit (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .we_i    (wb_LLbit_we),
    .value_i (wb_LLbit_value),
    .llbit_o (LLbit_o)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed scoreboard bench for wb_regfile
module tb_wb_regfile;
  logic clk = 0, rst = 1;
  logic wb_we = 0, wb_whilo = 0, wb_LLbit_we = 0, wb_LLbit_value = 0, flush = 0;
  logic re1 = 0, re2 = 0;
  logic [4:0] wb_waddr = 0, raddr1 = 0, raddr2 = 0;
  logic [31:0] wb_wdata = 0, wb_hi = 0, wb_lo = 0;
  logic [31:0] rdata1, rdata2, hi_o, lo_o;
  logic LLbit_o;
  int errors = 0, checks = 0;
  typedef enum int {S_RD1, S_RD2, S_HI, S_LO, S_LL} sig_e;
  typedef struct {string tag; sig_e sig; logic [31:0] val;} exp_t;
  exp_t sb [$];

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_LLbit_we(wb_LLbit_we),
    .wb_LLbit_value(wb_LLbit_value), .flush(flush), .re1(re1), .re2(re2),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .hi_o(hi_o), .lo_o(lo_o), .LLbit_o(LLbit_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_(input string tag, input sig_e sig, input logic [31:0] val);
    sb.push_back('{tag, sig, val});
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = e.sig == S_RD1 ? rdata1 : e.sig == S_RD2 ? rdata2 : e.sig == S_HI ? hi_o :
            e.sig == S_LO ? lo_o : {31'b0, LLbit_o};
      checks++;
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    tick();
    rst = 0;
    wb_we = 1; wb_waddr = 3; wb_wdata = 32'h5555_AAAA;
    wb_whilo = 1; wb_hi = 32'h1111; wb_lo = 32'h2222;
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    tick();
    rst = 1; wb_we = 0; wb_whilo = 0; wb_LLbit_we = 0; re1 = 1; raddr1 = 3;
    expect_("rd_during_rst", S_RD1, 0);
    expect_("ll_during_rst", S_LL, 0);
    drain();
    tick();
    rst = 0; re2 = 1;
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(31 - a);
      expect_("rst_rd1", S_RD1, 0);
      expect_("rst_rd2", S_RD2, 0);
      drain();
    end
    expect_("rst_hi", S_HI, 0);
    expect_("rst_lo", S_LO, 0);
    expect_("rst_ll", S_LL, 0);
    drain();

    wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEAD_BEEF;
    tick();
    wb_we = 0; re1 = 1; raddr1 = 5; re2 = 0; raddr2 = 5;
    expect_("wr_rd5", S_RD1, 32'hDEAD_BEEF);
    expect_("re2_off", S_RD2, 0);
    drain();

    re1 = 1; re2 = 1; raddr1 = 7; raddr2 = 7;
    expect_("old7_a", S_RD1, 0);
    expect_("old7_b", S_RD2, 0);
    drain();
    wb_we = 1; wb_waddr = 7; wb_wdata = 32'h1234;
    expect_("byp_rd1", S_RD1, 32'h1234);
    expect_("byp_rd2", S_RD2, 32'h1234);
    drain();
    tick();
    wb_wdata = 32'h5678;
    expect_("byp2_rd1", S_RD1, 32'h5678);
    expect_("byp2_rd2", S_RD2, 32'h5678);
    drain();
    wb_we = 0;
    expect_("nobyp_rd1", S_RD1, 32'h1234);
    expect_("nobyp_rd2", S_RD2, 32'h1234);
    drain();
    raddr2 = 5; wb_we = 1; wb_waddr = 7; wb_wdata = 32'h9999;
    expect_("byp_miss_rd2", S_RD2, 32'hDEAD_BEEF);
    drain();
    wb_we = 0;

    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF_FFFF; raddr1 = 0; raddr2 = 0;
    expect_("r0_same_1", S_RD1, 0);
    expect_("r0_same_2", S_RD2, 0);
    drain();
    tick();
    wb_we = 0;
    expect_("r0_next", S_RD1, 0);
    drain();

    wb_whilo = 1; wb_hi = 32'hA; wb_lo = 32'hB;
    expect_("hi_same", S_HI, 0);
    expect_("lo_same", S_LO, 0);
    drain();
    tick();
    wb_whilo = 0; wb_hi = 32'hC; wb_lo = 32'hD;
    expect_("hi_after", S_HI, 32'hA);
    expect_("lo_after", S_LO, 32'hB);
    drain();
    wb_waddr = 0; raddr1 = 5;
    tick();
    expect_("bub_hi", S_HI, 32'hA);
    expect_("bub_lo", S_LO, 32'hB);
    expect_("bub_r5", S_RD1, 32'hDEAD_BEEF);
    drain();

    wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_("ll_byp", S_LL, 1);
    drain();
    tick();
    wb_LLbit_we = 0;
    expect_("ll_hold", S_LL, 1);
    drain();
    flush = 1; wb_LLbit_we = 1; wb_LLbit_value = 1;
    expect_("ll_flush_same", S_LL, 0);
    drain();
    tick();
    flush = 0; wb_LLbit_we = 0;
    expect_("ll_flush_after", S_LL, 0);
    drain();
    wb_LLbit_we = 1; wb_LLbit_value = 1;
    tick();
    wb_LLbit_value = 0;
    expect_("ll_clr_byp", S_LL, 0);
    drain();
    tick();
    wb_LLbit_we = 0;
    expect_("ll_clr_held", S_LL, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
